uart_rx_word: RTL and testbench

//  Serial receive path paired with the CPU's uart_tx transmit path: same 8N1 framing and bit timing.

---
 rtl/uart_rx_word_pkg.sv | 15 +
 rtl/rx_word_fifo.sv | 55 +++++
 rtl/uart_rx_word.sv | 202 ++++++++++++++++++++
 tb/tb_uart_rx_word.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_word_pkg.sv
// rtl/uart_rx_word_pkg.sv - shared receiver state encoding and framing constants
package uart_rx_word_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } rx_state_t;

  localparam int DEFAULT_CLKS_PER_BIT = 434;
  localparam int BYTE_BITS            = 8;

endpackage

// File: rtl/rx_word_fifo.sv
// rtl/rx_word_fifo.sv - first-word-fall-through word FIFO with occupancy count
module rx_word_fifo #(
  parameter int FIFO_DEPTH = 4,
  parameter int FIFO_AW    = 2,
  parameter int DATA_W     = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic [DATA_W-1:0]  push_data,
  input  logic               pop,
  output logic [DATA_W-1:0]  rd_data,
  output logic               full,
  output logic               empty,
  output logic [FIFO_AW:0]   count
);

  logic [DATA_W-1:0]  mem [FIFO_DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic               pop_ok;
  logic               push_ok;

  assign full    = (count == (FIFO_AW+1)'(FIFO_DEPTH));
  assign empty   = (count == '0);
  assign rd_data = mem[rd_ptr];
  // A same-cycle pop frees the slot, so a push into a full FIFO still lands.
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push_ok && !pop_ok) begin
        count <= count + 1'b1;
      end else if (!push_ok && pop_ok) begin
        count <= count - 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_rx_word.sv
// rtl/uart_rx_word.sv - 8N1 UART receiver pairing bytes high-then-low into a word FIFO
module uart_rx_word
  import uart_rx_word_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int FIFO_DEPTH   = 4,
  parameter int FIFO_AW      = 2,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rx_serial,
  input  logic             rd_en,
  input  logic             clr_err,
  output logic [15:0]      rd_data,
  output logic             rd_valid,
  output logic             byte_valid,
  output logic [7:0]       byte_out,
  output logic [FIFO_AW:0] fifo_count,
  output logic             framing_err,
  output logic             overrun
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int TO_W  = $clog2(TIMEOUT_BITS + 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TIMEOUT_BITS);
  localparam logic [2:0]       IDX_LAST  = 3'(BYTE_BITS - 1);

  rx_state_t        state, state_n;
  logic             rx_meta, rx_s, armed;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [2:0]       idx, idx_n;
  logic [7:0]       shift, shift_n;
  logic             good_byte, frame_bad;
  logic             hi_pending;
  logic [7:0]       hi_byte;
  logic [CNT_W-1:0] to_cnt;
  logic [TO_W-1:0]  to_bits;
  logic             to_active, to_fire;
  logic             push, full, empty;

  // Sync flops reset low so armed waits for a genuine idle-high line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b0;
      rx_s    <= 1'b0;
      armed   <= 1'b0;
    end else begin
      rx_meta <= rx_serial;
      rx_s    <= rx_meta;
      if (rx_s) armed <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
      idx   <= '0;
      shift <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      idx   <= idx_n;
      shift <= shift_n;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    idx_n     = idx;
    shift_n   = shift;
    good_byte = 1'b0;
    frame_bad = 1'b0;
    case (state)
      ST_IDLE: begin
        if (armed && !rx_s) begin
          state_n = ST_START;
          cnt_n   = '0;
        end
      end
      ST_START: begin
        if (cnt == HALF_LAST) begin
          cnt_n   = '0;
          idx_n   = '0;
          state_n = rx_s ? ST_IDLE : ST_DATA;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      ST_DATA: begin
        if (cnt == BIT_LAST) begin
          cnt_n        = '0;
          shift_n[idx] = rx_s;
          if (idx == IDX_LAST) state_n = ST_STOP;
          else                 idx_n   = idx + 1'b1;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      ST_STOP: begin
        if (cnt == BIT_LAST) begin
          cnt_n = '0;
          if (rx_s) begin
            good_byte = 1'b1;
            state_n   = ST_IDLE;
          end else begin
            frame_bad = 1'b1;
            state_n   = ST_BREAK;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      ST_BREAK: begin
        if (rx_s) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_valid <= 1'b0;
      byte_out   <= '0;
    end else begin
      byte_valid <= good_byte;
      if (good_byte) byte_out <= shift;
    end
  end

  // A dangling high byte expires after TIMEOUT_BITS idle bit periods.
  assign to_active = hi_pending && (state == ST_IDLE);
  assign to_fire   = to_active && (to_bits == TO_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt  <= '0;
      to_bits <= '0;
    end else if (!to_active) begin
      to_cnt  <= '0;
      to_bits <= '0;
    end else if (to_cnt == BIT_LAST) begin
      to_cnt  <= '0;
      to_bits <= to_bits + 1'b1;
    end else begin
      to_cnt <= to_cnt + 1'b1;
    end
  end

  assign push = byte_valid && hi_pending;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_pending <= 1'b0;
      hi_byte    <= '0;
    end else if (frame_bad || to_fire) begin
      hi_pending <= 1'b0;
    end else if (byte_valid) begin
      if (hi_pending) begin
        hi_pending <= 1'b0;
      end else begin
        hi_byte    <= byte_out;
        hi_pending <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      framing_err <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      if (frame_bad)    framing_err <= 1'b1;
      else if (clr_err) framing_err <= 1'b0;
      if (push && full && !rd_en) overrun <= 1'b1;
      else if (clr_err)           overrun <= 1'b0;
    end
  end

  rx_word_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .FIFO_AW    (FIFO_AW),
    .DATA_W     (16)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data ({hi_byte, byte_out}),
    .pop       (rd_en),
    .rd_data   (rd_data),
    .full      (full),
    .empty     (empty),
    .count     (fifo_count)
  );

  assign rd_valid = !empty;

endmodule

// File: tb/tb_uart_rx_word.sv
// tb/tb_uart_rx_word.sv - scoreboard bench for uart_rx_word with a byte/word reference model
module tb_uart_rx_word;

  localparam int CPB   = 16;
  localparam int DEPTH = 4;
  localparam int AW    = 2;
  localparam int TMO   = 20;

  logic          clk = 1'b0;
  logic          rst;
  logic          rx_serial;
  logic          rd_en;
  logic          clr_err;
  logic [15:0]   rd_data;
  logic          rd_valid;
  logic          byte_valid;
  logic [7:0]    byte_out;
  logic [AW:0]   fifo_count;
  logic          framing_err;
  logic          overrun;

  always #5 clk = ~clk;

  uart_rx_word #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH),
    .FIFO_AW      (AW),
    .TIMEOUT_BITS (TMO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_serial   (rx_serial),
    .rd_en       (rd_en),
    .clr_err     (clr_err),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .byte_valid  (byte_valid),
    .byte_out    (byte_out),
    .fifo_count  (fifo_count),
    .framing_err (framing_err),
    .overrun     (overrun)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [7:0]  exp_bytes[$];
  logic [15:0] exp_words[$];
  bit          m_pending;
  logic [7:0]  m_hi;
  bit          m_ovr;
  bit          m_ferr;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    exp_bytes.delete();
    exp_words.delete();
    m_pending = 1'b0;
    m_ovr     = 1'b0;
    m_ferr    = 1'b0;
  endfunction

  // Receiver rules: a gap longer than the timeout drops a lone high byte,
  // a bad stop bit drops the byte and any pending high byte, pairs go to a 4-deep FIFO.
  function automatic void model_byte(input logic [7:0] b, input bit stop_ok, input int gap);
    if (gap > TMO) m_pending = 1'b0;
    if (!stop_ok) begin
      m_ferr    = 1'b1;
      m_pending = 1'b0;
      return;
    end
    exp_bytes.push_back(b);
    if (!m_pending) begin
      m_hi      = b;
      m_pending = 1'b1;
    end else begin
      m_pending = 1'b0;
      if (exp_words.size() < DEPTH) exp_words.push_back({m_hi, b});
      else                          m_ovr = 1'b1;
    end
  endfunction

  task automatic idle_bits(input int n);
    rx_serial = 1'b1;
    repeat (n * CPB) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit stop);
    rx_serial = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_serial = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx_serial = stop;
    repeat (CPB) @(negedge clk);
    rx_serial = 1'b1;
  endtask

  task automatic send(input logic [7:0] b, input int gap, input bit stop_ok);
    idle_bits(gap);
    model_byte(b, stop_ok, gap);
    send_frame(b, stop_ok);
    if (!stop_ok) idle_bits(1);
  endtask

  task automatic pop_one();
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 2 && exp_words.size() > 0; i++) pop_one();
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    m_ovr   = 1'b0;
    m_ferr  = 1'b0;
  endtask

  task automatic check_state(input string tag);
    #1;
    cmp({tag, " fifo_count"}, fifo_count, exp_words.size());
    cmp({tag, " rd_valid"}, rd_valid, exp_words.size() != 0);
    if (exp_words.size() != 0) cmp({tag, " rd_data head"}, rd_data, exp_words[0]);
    cmp({tag, " overrun"}, overrun, m_ovr);
    cmp({tag, " framing_err"}, framing_err, m_ferr);
    cmp({tag, " bytes outstanding"}, exp_bytes.size(), 0);
    @(negedge clk);
  endtask

  task automatic check_reset(input string tag);
    #1;
    cmp({tag, " rd_data"}, rd_data, 0);
    cmp({tag, " rd_valid"}, rd_valid, 0);
    cmp({tag, " byte_valid"}, byte_valid, 0);
    cmp({tag, " byte_out"}, byte_out, 0);
    cmp({tag, " fifo_count"}, fifo_count, 0);
    cmp({tag, " framing_err"}, framing_err, 0);
    cmp({tag, " overrun"}, overrun, 0);
    @(negedge clk);
  endtask

  // Monitor: every byte_valid and every accepted pop is checked against the model queues.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (byte_valid) begin
        if (exp_bytes.size() == 0) cmp("spurious byte_valid", byte_valid, 0);
        else                       cmp("byte_out", byte_out, exp_bytes.pop_front());
      end
      if (rd_en && rd_valid) begin
        if (exp_words.size() == 0) cmp("spurious word", rd_valid, 0);
        else                       cmp("rd_data pop", rd_data, exp_words.pop_front());
      end
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  lo;
    logic [15:0] w;
    bit          seen;
    int          gaps[5];
    gaps = '{0, 0, 1, 3, 25};

    rst       = 1'b1;
    rx_serial = 1'b1;
    rd_en     = 1'b0;
    clr_err   = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_reset("reset");
    rst = 1'b0;
    idle_bits(2);

    // 1: single word
    send(8'hA5, 0, 1'b1);
    send(8'h3C, 0, 1'b1);
    idle_bits(2);
    cmp("t1 word model", exp_words.size() == 1 ? exp_words[0] : 16'h0, 16'hA53C);
    check_state("t1");
    pop_one();
    check_state("t1 popped");

    // 2: overflow, then pop and push in the same cycle while full
    for (int i = 0; i < 10; i++) send(8'($urandom_range(255)), 0, 1'b1);
    idle_bits(2);
    check_state("t2 full");
    send(8'($urandom_range(255)), 0, 1'b1);
    lo = 8'($urandom_range(255));
    exp_bytes.push_back(lo);
    w         = {m_hi, lo};
    m_pending = 1'b0;
    seen      = 1'b0;
    fork
      send_frame(lo, 1'b1);
      begin
        for (int i = 0; i < 12 * CPB && !seen; i++) begin
          @(negedge clk);
          if (byte_valid) seen = 1'b1;
        end
        if (seen) pop_one();
      end
    join
    cmp("t2 pop/push byte_valid seen", seen, 1);
    exp_words.push_back(w);
    idle_bits(2);
    check_state("t2 pop+push");
    pulse_clr();
    check_state("t2 cleared");
    drain();
    pop_one();
    check_state("t2 drained");

    // 3: framing error then recovery
    send(8'h55, 0, 1'b0);
    idle_bits(2);
    check_state("t3 ferr");
    send(8'h12, 1, 1'b1);
    send(8'h34, 0, 1'b1);
    idle_bits(2);
    check_state("t3 word");
    pulse_clr();
    check_state("t3 cleared");
    drain();

    // 4: short glitch, then reset mid-frame with the line held low
    rx_serial = 1'b0;
    repeat (6) @(negedge clk);
    idle_bits(2);
    check_state("t4 glitch");
    rx_serial = 1'b0;
    repeat (3 * CPB) @(negedge clk);
    rst = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    check_reset("t4 reset");
    rst = 1'b0;
    repeat (4 * CPB) @(negedge clk);
    idle_bits(3);
    check_state("t4 after reset");
    send(8'hC3, 0, 1'b1);
    send(8'h7E, 0, 1'b1);
    idle_bits(2);
    check_state("t4 word");
    drain();

    // 5: timeout drops a lone high byte
    send(8'h12, 2, 1'b1);
    send(8'h34, 25, 1'b1);
    send(8'h56, 0, 1'b1);
    idle_bits(2);
    cmp("t5 word model", exp_words.size() == 1 ? exp_words[0] : 16'h0, 16'h3456);
    check_state("t5");
    drain();

    // 6: back-to-back bytes
    for (int i = 0; i < 8; i++) send(8'($urandom_range(255)), 0, 1'b1);
    idle_bits(2);
    check_state("t6");
    drain();
    check_state("t6 drained");

    // random mix of gaps and bad stop bits
    for (int i = 0; i < 24; i++) begin
      send(8'($urandom_range(255)), gaps[$urandom_range(4)], $urandom_range(7) != 0);
      if (exp_words.size() == DEPTH) begin
        idle_bits(1);
        drain();
      end
    end
    idle_bits(2);
    check_state("rand");
    drain();
    check_state("rand drained");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
